// File: rtl/conway_frame_reader.sv
// conway_frame_reader: snapshots the Conway cell array into a private frame
// buffer and streams it out one row per beat over a valid/ready interface.
// Optional feature macro: CONWAY_READER_POPCOUNT_EN (live-cell count of the
// captured frame on `population`; tied to zero when undefined).
module conway_frame_reader #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ROWS*COLS-1:0]                 grid,
  input  logic                                 snap,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [COLS-1:0]                      m_data,
  output logic [$clog2(ROWS)-1:0]              m_row,
  output logic                                 m_last,
  output logic                                 busy,
  output logic [7:0]                           drop_count,
  output logic [$clog2(ROWS*COLS+1)-1:0]       population
);

  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(ROWS*COLS+1);
  localparam int N  = ROWS*COLS;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    frame_q, frame_d;
  logic [RW-1:0]   row_q, row_d;
  logic            valid_q, valid_d;
  logic [COLS-1:0] data_q, data_d;
  logic            last_q, last_d;
  logic [7:0]      drop_q, drop_d;
  logic            capture;
  logic            hs;
  logic [RW-1:0]   row_nxt;

  // Row view of the frame buffer so the next beat can be selected by row index.
  logic [COLS-1:0] frame_rows [ROWS];
  for (genvar r = 0; r < ROWS; r++) begin : g_rows
    assign frame_rows[r] = frame_q[r*COLS +: COLS];
  end

  // Next-state and next-output logic; every output comes from a flop.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    row_d   = row_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    drop_d  = drop_q;
    capture = 1'b0;
    hs      = valid_q & m_ready;
    row_nxt = row_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (snap) capture = 1'b1;
      end
      STREAM: begin
        if (hs && row_q == LAST_ROW) begin
          // A snap landing on the final handshake starts the next frame with no bubble.
          if (snap) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            row_d   = '0;
            data_d  = '0;
          end
        end else begin
          if (hs) begin
            row_d  = row_nxt;
            data_d = frame_rows[row_nxt];
            last_d = (row_nxt == LAST_ROW);
          end
          // Any other snap while streaming is lost; count it, saturating.
          if (snap && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      frame_d = grid;
      row_d   = '0;
      state_d = STREAM;
      valid_d = 1'b1;
      data_d  = grid[COLS-1:0];
      last_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  assign m_valid    = valid_q;
  assign m_data     = data_q;
  assign m_row      = row_q;
  assign m_last     = last_q;
  assign busy       = (state_q == STREAM);
  assign drop_count = drop_q;

`ifdef CONWAY_READER_POPCOUNT_EN
  logic [PW-1:0] pop_q, pop_d;

  function automatic logic [PW-1:0] popcnt(input logic [N-1:0] v);
    logic [PW-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) acc = acc + PW'(v[i]);
    return acc;
  endfunction

  // Count is taken from the same grid sample that fills the frame buffer.
  always_comb begin
    pop_d = pop_q;
    if (capture) pop_d = popcnt(grid);
  end

  // Population register, held until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pop_q <= '0;
    else     pop_q <= pop_d;
  end

  assign population = pop_q;
`else
  assign population = '0;
`endif

endmodule

// File: tb/tb_conway_frame_reader.sv
// Randomized scoreboard bench for conway_frame_reader (ROWS=COLS=8).
// A frame-level model predicts every accepted beat; a monitor compares.
module tb_conway_frame_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] grid = '0;
  logic        snap = 1'b0;
  logic        m_ready = 1'b0;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [2:0]  m_row;
  logic        m_last;
  logic        busy;
  logic [7:0]  drop_count;
  logic [6:0]  population;

  conway_frame_reader #(.ROWS(8), .COLS(8)) dut (
    .clk(clk), .rst(rst), .grid(grid), .snap(snap),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
    .m_last(m_last), .busy(busy), .drop_count(drop_count), .population(population)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] row;
    logic [7:0] data;
    logic       last;
    logic [6:0] pop;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    m_in_flight = 0;
  int    m_left = 0;
  int    exp_drops = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_pop(input logic [63:0] g);
`ifdef CONWAY_READER_POPCOUNT_EN
    return 7'($countones(g));
`else
    return 7'd0;
`endif
  endfunction

  // Reference model: a frame is a list of 8 row beats; a snap either opens a
  // new frame (idle, or on the final beat's handshake) or is counted as lost.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_in_flight = 0;
      m_left = 0;
      exp_drops = 0;
    end else begin
      bit hs, acc;
      hs  = m_in_flight && m_ready;
      acc = snap && (!m_in_flight || (hs && m_left == 1));
      if (hs) begin
        m_left--;
        if (m_left == 0) m_in_flight = 0;
      end
      if (acc) begin
        for (int r = 0; r < 8; r++) begin
          beat_t b;
          b.row  = 3'(r);
          b.data = grid[r*8 +: 8];
          b.last = (r == 7);
          b.pop  = exp_pop(grid);
          exp_q.push_back(b);
        end
        m_in_flight = 1;
        m_left = 8;
      end else if (snap) begin
        if (exp_drops < 255) exp_drops++;
      end
    end
  end

  // Monitor: mid-cycle, compare status and pop/compare each accepted beat.
  initial begin
    bit         prev_stall = 0;
    logic [2:0] prev_row = '0;
    logic [7:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        continue;
      end
      chk("m_valid", 64'(m_valid), 64'(m_in_flight));
      chk("busy", 64'(busy), 64'(m_in_flight));
      chk("drop_count", 64'(drop_count), 64'(exp_drops));
      if (!m_valid) chk("m_last_idle", 64'(m_last), 64'd0);
      if (prev_stall) begin
        chk("hold_row", 64'(m_row), 64'(prev_row));
        chk("hold_data", 64'(m_data), 64'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(m_row), 64'hFFFF);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("beat_row", 64'(m_row), 64'(b.row));
          chk("beat_data", 64'(m_data), 64'(b.data));
          chk("beat_last", 64'(m_last), 64'(b.last));
          chk("population", 64'(population), 64'(b.pop));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_row   = m_row;
      prev_data  = m_data;
    end
  end

  function automatic logic [63:0] rgrid();
    return {$urandom, $urandom};
  endfunction

  // Drive one cycle's inputs shortly after the rising edge.
  task automatic cyc(input bit s, input bit r, input logic [63:0] g);
    @(posedge clk);
    #2;
    snap = s;
    m_ready = r;
    grid = g;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, rgrid());
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_row", 64'(m_row), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_pop", 64'(population), 64'd0);

    // Blinker, full throughput
    cyc(1'b1, 1'b1, 64'h0000_0000_0000_0700);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 64'h0000_0000_0000_0700);

    // Backpressure on row 3 while the grid keeps changing
    for (int i = 0; i < 16; i++) cyc(i == 0, !(i >= 4 && i < 9), rgrid());
    idle(2);

    // Two extra snaps mid-frame
    for (int i = 0; i < 12; i++) cyc(i == 0 || i == 3 || i == 5, 1'b1, rgrid());
    @(negedge clk);
    chk("drop_two", 64'(drop_count), 64'd2);

    // 300 snaps while stalled: counter saturates
    for (int i = 0; i < 301; i++) cyc(1'b1, 1'b0, rgrid());
    idle(12);
    @(negedge clk);
    chk("drop_sat", 64'(drop_count), 64'd255);

    // Snap on the last-row handshake: back-to-back frames
    for (int i = 0; i < 20; i++) cyc(i == 0 || i == 8, 1'b1, rgrid());
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7, rgrid());
    idle(20);

    // Asynchronous reset during row 5
    for (int i = 0; i < 7; i++) cyc(i == 0, 1'b1, rgrid());
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(m_valid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_drop", 64'(drop_count), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 12; i++) cyc(i == 0, 1'b1, rgrid());

    // More random traffic after reset, then drain
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 9) < 6, rgrid());
    idle(20);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
